dma_controller_xfer: RTL
========================

DMA_CONTROLLER_XFER -- requirements
Module: dma_controller_xfer

Interface
REQ-001 Parameter CHANNELS_AMOUNT, default 4, number of DMA channels served.
REQ-002 Parameter CHANNEL_CNT_W, default $clog2(CHANNELS_AMOUNT), channel index width.
REQ-003 Parameter ADDR_W, default 32, memory address width; DATA_W, default 32, data width; CNT_W, default 16, transfer counter width.
REQ-004 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  input  1  arbiter presents a granted channel.
REQ-007 req_num_i  input  CHANNEL_CNT_W  granted channel index, valid with req_valid_i.
REQ-008 ready_o  output  1  engine accepts a grant; handshake completes when req_valid_i && ready_o.
REQ-009 acknowledge_o  output  [CHANNELS_AMOUNT-1:0] unpacked  one-cycle per-channel beat-done pulse.
REQ-010 ch_load_i  input  [CHANNELS_AMOUNT-1:0] unpacked  per-channel load strobe for config below.
REQ-011 ch_src_addr_i / ch_dst_addr_i  input  ADDR_W each, per channel  start addresses.
REQ-012 ch_cnt_i  input  CNT_W per channel  beats to transfer; ch_src_inc_i / ch_dst_inc_i  input  1 per channel  address increment enables.
REQ-013 tc_o  output  [CHANNELS_AMOUNT-1:0]  one-cycle transfer-complete pulse; err_o  output  [CHANNELS_AMOUNT-1:0]  one-cycle pulse, grant with zero count.
REQ-014 mm_address_o ADDR_W, mm_read_o 1, mm_write_o 1, mm_writedata_o DATA_W outputs; mm_readdata_i DATA_W, mm_readdatavalid_i 1, mm_waitrequest_i 1 inputs: memory-mapped master port.

Function
REQ-015 Per channel, engine SHALL hold cur_src, cur_dst (ADDR_W) and remaining (CNT_W), loaded from inputs on ch_load_i[i].
REQ-016 FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, ACK; ready_o SHALL be 1 only in IDLE.
REQ-017 IDLE: on req_valid_i, latch req_num_i into ch_q; if remaining[ch_q]==0 go ACK with error flag, else go RD_REQ.
REQ-018 RD_REQ: mm_read_o=1, mm_address_o=cur_src[ch_q]; held stable until mm_waitrequest_i==0, then RD_WAIT.
REQ-019 RD_WAIT: on mm_readdatavalid_i, capture mm_readdata_i into data register, go WR_REQ; readdatavalid in the same cycle as accepted read SHALL also be captured (go directly WR_REQ).
REQ-020 WR_REQ: mm_write_o=1, mm_address_o=cur_dst[ch_q], mm_writedata_o=data register; held until mm_waitrequest_i==0, then ACK.
REQ-021 ACK (one cycle): acknowledge_o[ch_q]=1; if not error: remaining decremented, cur_src += DATA_W/8 when src_inc, cur_dst += DATA_W/8 when dst_inc; tc_o[ch_q]=1 when remaining was 1; err_o[ch_q]=1 when error; then IDLE.
REQ-022 Address increment SHALL wrap modulo 2^ADDR_W; remaining SHALL never decrement below 0.
REQ-023 mm_read_o and mm_write_o SHALL never be asserted together; at most one outstanding read.
REQ-024 ch_load_i[i] coinciding with ACK for channel i: load SHALL win, decrement discarded.
REQ-025 ch_load_i[i] while channel i is in flight: registers reload, in-flight beat completes with latched address, ACK update SHALL not overwrite loaded values.
REQ-026 Minimum grant-to-acknowledge latency with zero wait states and readdatavalid one cycle after read accept: 4 cycles (IDLE->RD_REQ->RD_WAIT->WR_REQ->ACK).
REQ-027 req_num_i >= CHANNELS_AMOUNT SHALL be treated as error grant on no channel: no bus access, no pulses, return to IDLE.

Reset
REQ-028 On rst_i: FSM=IDLE, ready_o=1, mm_read_o=0, mm_write_o=0, mm_address_o=0, mm_writedata_o=0, all acknowledge_o/tc_o/err_o=0, all cur_src/cur_dst/remaining=0.
REQ-029 Reset mid-transfer SHALL drop bus request immediately (asynchronous) with no acknowledge issued.

Structure
REQ-030 FSM state enum and address step constant SHALL reside in dma_controller_pkg.
REQ-031 Per-channel register set SHALL be a sub-module dma_controller_ch_regs, instantiated CHANNELS_AMOUNT times.

Verification
REQ-032 Ch2 loaded src=0x100, dst=0x200, cnt=2, both inc; two grants, zero waits -> writes to 0x200 then 0x204 with read data, acknowledge_o[2] twice, tc_o[2] on second, 4-cycle latency each.
REQ-033 Grant ch1 with cnt=0 -> no mm_read_o/mm_write_o, acknowledge_o[1] and err_o[1] pulse, ready_o back in 2 cycles.
REQ-034 mm_waitrequest_i high 3 cycles in RD_REQ and WR_REQ -> address/strobes stable throughout, latency 10 cycles.
REQ-035 src=0xFFFF_FFFC inc, cnt=2 -> second read at 0x0000_0000.
REQ-036 rst_i asserted during WR_REQ -> mm_write_o low same cycle, no acknowledge, ready_o=1 after release.
REQ-037 ch_load_i[0] in ACK cycle of ch0 with cnt=5 -> remaining[0]=5, no tc_o.

Source files
------------

// File: rtl/dma_controller_pkg.sv
// Shared types and constants for the DMA transfer engine and its channel register sets.
package dma_controller_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      ACK
   } xfer_state_t;

   localparam int unsigned BYTE_W = 8;

   // Address step per beat is one full data word, expressed in bytes.
   function automatic int unsigned addr_step(input int unsigned data_w);
      return data_w / BYTE_W;
   endfunction

endpackage

// File: rtl/dma_controller_ch_regs.sv
// Per-channel current source/destination address and remaining beat count.
// A load always takes priority over the per-beat update from the engine.
module dma_controller_ch_regs
   import dma_controller_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [CNT_W-1:0]  cnt,
   input  logic              src_inc,
   input  logic              dst_inc,
   input  logic              update,
   output logic [ADDR_W-1:0] cur_src,
   output logic [ADDR_W-1:0] cur_dst,
   output logic [CNT_W-1:0]  remaining
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(addr_step(DATA_W));

   // Address adds wrap naturally at ADDR_W bits; the count saturates at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_src   <= '0;
         cur_dst   <= '0;
         remaining <= '0;
      end else if (load) begin
         cur_src   <= src_addr;
         cur_dst   <= dst_addr;
         remaining <= cnt;
      end else if (update && (remaining != '0)) begin
         remaining <= remaining - CNT_W'(1);
         if (src_inc) cur_src <= cur_src + STEP;
         if (dst_inc) cur_dst <= cur_dst + STEP;
      end
   end

endmodule

// File: rtl/dma_controller_xfer.sv
// DMA transfer engine: moves one beat per grant from a channel's source to its destination
// over a memory-mapped master port, then pulses acknowledge/terminal-count/error for that channel.
module dma_controller_xfer
   import dma_controller_pkg::*;
#(
   parameter int CHANNELS_AMOUNT = 4,
   parameter int CHANNEL_CNT_W   = $clog2(CHANNELS_AMOUNT),
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int CNT_W           = 16
)(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       req_valid_i,
   input  logic [CHANNEL_CNT_W-1:0]   req_num_i,
   output logic                       ready_o,
   output logic                       acknowledge_o [CHANNELS_AMOUNT-1:0],
   input  logic                       ch_load_i     [CHANNELS_AMOUNT-1:0],
   input  logic [ADDR_W-1:0]          ch_src_addr_i [CHANNELS_AMOUNT-1:0],
   input  logic [ADDR_W-1:0]          ch_dst_addr_i [CHANNELS_AMOUNT-1:0],
   input  logic [CNT_W-1:0]           ch_cnt_i      [CHANNELS_AMOUNT-1:0],
   input  logic                       ch_src_inc_i  [CHANNELS_AMOUNT-1:0],
   input  logic                       ch_dst_inc_i  [CHANNELS_AMOUNT-1:0],
   output logic [CHANNELS_AMOUNT-1:0] tc_o,
   output logic [CHANNELS_AMOUNT-1:0] err_o,
   output logic [ADDR_W-1:0]          mm_address_o,
   output logic                       mm_read_o,
   output logic                       mm_write_o,
   output logic [DATA_W-1:0]          mm_writedata_o,
   input  logic [DATA_W-1:0]          mm_readdata_i,
   input  logic                       mm_readdatavalid_i,
   input  logic                       mm_waitrequest_i
);

   xfer_state_t state, state_nxt;

   logic [CHANNEL_CNT_W-1:0] ch_q;
   logic                     err_q;
   logic                     last_q;
   logic                     reload_q;
   logic [ADDR_W-1:0]        src_q;
   logic [ADDR_W-1:0]        dst_q;
   logic [DATA_W-1:0]        data_q;

   logic [ADDR_W-1:0] cur_src   [CHANNELS_AMOUNT];
   logic [ADDR_W-1:0] cur_dst   [CHANNELS_AMOUNT];
   logic [CNT_W-1:0]  remaining [CHANNELS_AMOUNT];
   logic              update    [CHANNELS_AMOUNT];

   logic grant_ok;
   logic grant_zero;
   logic capture;

   // Out-of-range channel numbers are accepted but ignored: no bus access, no pulses.
   assign grant_ok   = (state == IDLE) && req_valid_i && (int'(req_num_i) < CHANNELS_AMOUNT);
   assign grant_zero = (remaining[req_num_i] == '0);
   assign capture    = mm_readdatavalid_i &&
                       ((state == RD_WAIT) || ((state == RD_REQ) && !mm_waitrequest_i));

   for (genvar i = 0; i < CHANNELS_AMOUNT; i++) begin : g_ch
      // A reload seen at any point during the beat suppresses the ACK-time update.
      assign update[i] = (state == ACK) && (int'(ch_q) == i) && !err_q && !reload_q;

      dma_controller_ch_regs #(
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_regs (
         .clk       (clk_i),
         .rst       (rst_i),
         .load      (ch_load_i[i]),
         .src_addr  (ch_src_addr_i[i]),
         .dst_addr  (ch_dst_addr_i[i]),
         .cnt       (ch_cnt_i[i]),
         .src_inc   (ch_src_inc_i[i]),
         .dst_inc   (ch_dst_inc_i[i]),
         .update    (update[i]),
         .cur_src   (cur_src[i]),
         .cur_dst   (cur_dst[i]),
         .remaining (remaining[i])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         ch_q     <= '0;
         err_q    <= 1'b0;
         last_q   <= 1'b0;
         reload_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant_ok) begin
            ch_q     <= req_num_i;
            err_q    <= grant_zero;
            last_q   <= (remaining[req_num_i] == CNT_W'(1));
            reload_q <= 1'b0;
         end else if ((state != IDLE) && ch_load_i[ch_q]) begin
            reload_q <= 1'b1;
         end
      end
   end

   // Beat addresses are latched at grant so a mid-flight reload cannot disturb the bus.
   always_ff @(posedge clk_i) begin
      if (grant_ok) begin
         src_q <= cur_src[req_num_i];
         dst_q <= cur_dst[req_num_i];
      end
      if (capture) data_q <= mm_readdata_i;
   end

   always_comb begin
      state_nxt      = state;
      ready_o        = 1'b0;
      mm_read_o      = 1'b0;
      mm_write_o     = 1'b0;
      mm_address_o   = '0;
      mm_writedata_o = '0;
      tc_o           = '0;
      err_o          = '0;
      for (int i = 0; i < CHANNELS_AMOUNT; i++) acknowledge_o[i] = 1'b0;

      unique case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (grant_ok) state_nxt = grant_zero ? ACK : RD_REQ;
         end
         RD_REQ: begin
            mm_read_o    = 1'b1;
            mm_address_o = src_q;
            if (!mm_waitrequest_i) state_nxt = mm_readdatavalid_i ? WR_REQ : RD_WAIT;
         end
         RD_WAIT: begin
            if (mm_readdatavalid_i) state_nxt = WR_REQ;
         end
         WR_REQ: begin
            mm_write_o     = 1'b1;
            mm_address_o   = dst_q;
            mm_writedata_o = data_q;
            if (!mm_waitrequest_i) state_nxt = ACK;
         end
         ACK: begin
            acknowledge_o[ch_q] = 1'b1;
            tc_o[ch_q]          = !err_q && last_q && !reload_q && !ch_load_i[ch_q];
            err_o[ch_q]         = err_q;
            state_nxt           = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
